sorted_insert: RTL and testbench

- Writer-side counterpart of the binary-search reader: maintains a DEPTH x WIDTH RAM in unsigned ascending order by insertion.
- Each insertion scans down from the top entry. Entries larger than the new value shift up one slot, then the value is written into the gap.
- A registered external read port exposes the sorted contents to the search block while this block is idle.

---
 rtl/sorted_insert_pkg.sv | 42 ++++
 rtl/sorted_insert_if.sv | 27 ++
 rtl/sorted_insert_ram.sv | 29 ++
 rtl/sorted_insert.sv | 198 +++++++++++++++++++
 tb/tb_sorted_insert.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/sorted_insert_pkg.sv
// sorted_mem_pkg: shared types and defaults for the sorted_insert block.
//   - state_t    : insertion FSM states (S_PRE only with SORTED_INSERT_DUP_REJECT_EN)
//   - DEFAULT_*  : default RAM geometry
//   - state_busy : decodes which states own the RAM address port
package sorted_mem_pkg;

  localparam int unsigned DEFAULT_DEPTH = 32'd32;
  localparam int unsigned DEFAULT_WIDTH = 32'd8;

`ifdef SORTED_INSERT_DUP_REJECT_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CMP  = 3'd2,
    S_PUT  = 3'd3,
    S_DONE = 3'd4,
    S_PRE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CMP  = 3'd2,
    S_PUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;
`endif

  // High while the FSM, not the external reader, drives the RAM address.
  function automatic logic state_busy(input state_t s);
    logic b;
    case (s)
      S_RD, S_CMP, S_PUT: b = 1'b1;
`ifdef SORTED_INSERT_DUP_REJECT_EN
      S_PRE:              b = 1'b1;
`endif
      default:            b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sorted_insert_if.sv
// sorted_insert_if: request/status/read-port bundle of sorted_insert.
//   master (producer / search block): drives A, start, rd_addr
//   slave  (sorted_insert)          : drives rd_data, loc, count, busy, done, rejected
interface sorted_insert_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
);
  logic [WIDTH-1:0] A;
  logic             start;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    loc;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic             rejected;

  modport master (
    output A, start, rd_addr,
    input  rd_data, loc, count, busy, done, rejected
  );

  modport slave (
    input  A, start, rd_addr,
    output rd_data, loc, count, busy, done, rejected
  );
endinterface

// File: rtl/sorted_insert_ram.sv
// sorted_ram: DEPTH x WIDTH single-port RAM, synchronous write, registered read.
//   i_addr  : shared read/write address
//   i_we    : write enable (write i_wdata to mem[i_addr])
//   i_wdata : write data
//   o_rdata : mem[i_addr] one clock after the address (old data on a write cycle)
// Contents are not reset; the owner tracks which entries are valid.
module sorted_ram #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    i_addr,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage array write and registered read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/sorted_insert.sv
// sorted_insert: keeps a DEPTH x WIDTH RAM in unsigned ascending order.
// Each accepted start scans down from the top valid entry, shifting larger
// entries up one slot, then writes A into the gap. While idle, the RAM read
// port is handed to the external reader through rd_addr/rd_data.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : sorted_insert_if.slave (A, start, rd_addr in; rd_data, loc,
//           count, busy, done, rejected out)
// Build option: SORTED_INSERT_DUP_REJECT_EN makes an insert of a value already
// present finish with rejected=1 and loc at the existing copy, leaving RAM
// untouched (a read-only pre-scan runs before any shifting).
module sorted_insert
  import sorted_mem_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  sorted_insert_if.slave bus
);

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_a_q,    w_a_nxt;
  logic [AW-1:0]    r_idx,    w_idx_nxt;
  logic [AW-1:0]    r_loc,    w_loc_nxt;
  logic [AW:0]      r_count,  w_count_nxt;
  logic             r_rej,    w_rej_nxt;
  logic             r_busy,   r_done;
`ifdef SORTED_INSERT_DUP_REJECT_EN
  logic             r_pre,    w_pre_nxt;
`endif

  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_q;

  // Idle: the external reader owns the address; busy: write address or scan index.
  assign w_addr = (!r_busy) ? bus.rd_addr : (w_we ? w_waddr : r_idx);

  sorted_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_addr),
    .i_we    (w_we),
    .i_wdata (w_wdata),
    .o_rdata (w_q)
  );

  assign bus.rd_data  = w_q;
  assign bus.loc      = r_loc;
  assign bus.count    = r_count;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rejected = r_rej;

  // Next-state, datapath update and RAM write control.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a_q;
    w_idx_nxt   = r_idx;
    w_loc_nxt   = r_loc;
    w_count_nxt = r_count;
    w_rej_nxt   = r_rej;
    w_we        = 1'b0;
    w_waddr     = r_idx;
    w_wdata     = r_a_q;
`ifdef SORTED_INSERT_DUP_REJECT_EN
    w_pre_nxt   = r_pre;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_nxt   = bus.A;
          w_rej_nxt = 1'b0;
          if (r_count == (AW+1)'(DEPTH)) begin
            w_rej_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else if (r_count == (AW+1)'(0)) begin
            w_loc_nxt   = AW'(0);
            w_state_nxt = S_PUT;
          end else begin
            w_idx_nxt   = AW'(r_count - (AW+1)'(1));
`ifdef SORTED_INSERT_DUP_REJECT_EN
            w_pre_nxt   = 1'b1;
            w_state_nxt = S_PRE;
`else
            w_state_nxt = S_RD;
`endif
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        w_state_nxt = S_CMP;
      end
`ifdef SORTED_INSERT_DUP_REJECT_EN
      S_PRE: begin
        w_state_nxt = S_CMP;
      end
`endif
      S_CMP: begin
`ifdef SORTED_INSERT_DUP_REJECT_EN
        // Pre-scan: read-only pass; stops at the first entry not above a_q.
        if (r_pre) begin
          if (w_q == r_a_q) begin
            w_rej_nxt   = 1'b1;
            w_loc_nxt   = r_idx;
            w_pre_nxt   = 1'b0;
            w_state_nxt = S_DONE;
          end else if ((w_q < r_a_q) || (r_idx == AW'(0))) begin
            w_idx_nxt   = AW'(r_count - (AW+1)'(1));
            w_pre_nxt   = 1'b0;
            w_state_nxt = S_RD;
          end else begin
            w_idx_nxt   = r_idx - AW'(1);
            w_state_nxt = S_PRE;
          end
        end else
`endif
        begin
          if (w_q > r_a_q) begin
            // idx <= count-1 <= DEPTH-2 here, so idx+1 stays in range.
            w_we    = 1'b1;
            w_waddr = r_idx + AW'(1);
            w_wdata = w_q;
            if (r_idx == AW'(0)) begin
              w_loc_nxt   = AW'(0);
              w_state_nxt = S_PUT;
            end else begin
              w_idx_nxt   = r_idx - AW'(1);
              w_state_nxt = S_RD;
            end
          end else begin
            // Equal values stop here too: duplicates land after existing equals.
            w_loc_nxt   = r_idx + AW'(1);
            w_state_nxt = S_PUT;
          end
        end
      end
      S_PUT: begin
        w_we        = 1'b1;
        w_waddr     = r_loc;
        w_wdata     = r_a_q;
        w_count_nxt = r_count + (AW+1)'(1);
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // start is level-held; wait for its release so one request = one insert.
        if (!bus.start) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and status registers; busy/done registered from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a_q   <= '0;
      r_idx   <= '0;
      r_loc   <= '0;
      r_count <= '0;
      r_rej   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SORTED_INSERT_DUP_REJECT_EN
      r_pre   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_a_q   <= w_a_nxt;
      r_idx   <= w_idx_nxt;
      r_loc   <= w_loc_nxt;
      r_count <= w_count_nxt;
      r_rej   <= w_rej_nxt;
      r_busy  <= state_busy(w_state_nxt);
      r_done  <= (w_state_nxt == S_DONE);
`ifdef SORTED_INSERT_DUP_REJECT_EN
      r_pre   <= w_pre_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sorted_insert.sv
// Directed, table-driven bench for sorted_insert (default build).
module tb_sorted_insert;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sorted_insert_if #(.WIDTH(8), .AW(5)) bus ();

  sorted_insert #(.DEPTH(32), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    int         loc;
    int         cnt;
    int         lat;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #7;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Raise start, count edges from the accepting edge until done, drop start.
  task automatic do_insert(input logic [7:0] a, output int lat, output int loc,
                           output int cnt, output int rej);
    bus.A     = a;
    bus.start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!bus.done && lat < 200);
    loc = int'(bus.loc);
    cnt = int'(bus.count);
    rej = int'(bus.rejected);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, output int data);
    bus.rd_addr = addr;
    @(posedge clk);
    #1;
    data = int'(bus.rd_data);
  endtask

  initial begin
    int lat, loc, cnt, rej, d;
    int exp_mem[5];
    checks = 0;
    errors = 0;
    bus.A = 8'd0;
    bus.start = 1'b0;
    bus.rd_addr = 5'd0;
    reset = 1'b0;

    // From 50: 50 -> 10 -> 90 -> 50 -> 30.
    // Contents before the second 50 are 10,50,90: 90 shifts, 50 stops, loc=2.
    tbl[0] = '{8'd50, 0, 1, 2};
    tbl[1] = '{8'd10, 0, 2, 4};
    tbl[2] = '{8'd90, 2, 3, 4};
    tbl[3] = '{8'd50, 2, 4, 6};
    tbl[4] = '{8'd30, 1, 5, 10};
    exp_mem = '{10, 30, 50, 50, 90};

    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_loc", int'(bus.loc), 0);
    chk("rst_rej", int'(bus.rejected), 0);
    #20;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven insert sequence.
    for (int i = 0; i < 5; i++) begin
      do_insert(tbl[i].a, lat, loc, cnt, rej);
      chk($sformatf("tbl%0d_loc", i), loc, tbl[i].loc);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_rej", i), rej, 0);
      if (i == 0) begin
        rd(5'd0, d);
        chk("first_mem0", d, 50);
      end
    end
    for (int i = 0; i < 5; i++) begin
      rd(5'(i), d);
      chk($sformatf("sorted_mem%0d", i), d, exp_mem[i]);
    end

    // Start held through done: exactly one insertion.
    bus.A = 8'd200;
    bus.start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!bus.done && lat < 200);
    chk("hold_lat", lat, 2 + 2 * 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("hold_done", int'(bus.done), 1);
      chk("hold_busy", int'(bus.busy), 0);
      chk("hold_cnt", int'(bus.count), 6);
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_done", int'(bus.done), 0);
    chk("rel_busy", int'(bus.busy), 0);
    chk("rel_cnt", int'(bus.count), 6);
    rd(5'd5, d);
    chk("hold_mem5", d, 200);

    // Descending fill: every insert shifts all entries to the top.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      do_insert(8'(255 - i), lat, loc, cnt, rej);
      chk($sformatf("fill%0d_loc", i), loc, 0);
      chk($sformatf("fill%0d_cnt", i), cnt, i + 1);
      chk($sformatf("fill%0d_lat", i), lat, 2 + 2 * i);
    end
    do_insert(8'd7, lat, loc, cnt, rej);
    chk("full_lat", lat, 1);
    chk("full_rej", rej, 1);
    chk("full_cnt", cnt, 32);
    chk("full_loc", loc, 0);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), d);
      chk($sformatf("full_mem%0d", i), d, 224 + i);
    end

    // Asynchronous reset in the middle of a long shift.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_insert(8'(100 + i), lat, loc, cnt, rej);
    end
    chk("pre_abort_cnt", cnt, 20);
    bus.A = 8'd0;
    bus.start = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("mid_busy", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_cnt", int'(bus.count), 0);
    chk("abort_loc", int'(bus.loc), 0);
    chk("abort_rej", int'(bus.rejected), 0);
    bus.start = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_insert(8'd5, lat, loc, cnt, rej);
    chk("after_abort_loc", loc, 0);
    chk("after_abort_cnt", cnt, 1);
    chk("after_abort_lat", lat, 2);
    rd(5'd0, d);
    chk("after_abort_mem0", d, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
